// File: rtl/packed_record_fifo.sv
`default_nettype none
// ============================================================================
// Module   : packed_record_fifo
// Purpose  : FIFO of nested packed-struct records {hdr{tag,len}, data}.
//            The head-entry fields are exposed as separate output ports.
//            When MERGE=1, a write whose tag matches the tail record is
//            coalesced into it: the payloads are summed and hdr.len is
//            incremented. A plain push is used instead when the tail would
//            overflow len, or when the tail is being popped this cycle.
// Ports    : clk, rst       - clock and synchronous active-high reset
//            in_valid/in_ready, in_tag, in_data
//                           - write handshake and the incoming record
//            out_valid/out_ready, out_tag, out_len, out_data
//                           - pop handshake and the head record fields
//                             (the fields are zero when the FIFO is empty)
//            count          - current occupancy
// Revision : 1.0  initial release
// ============================================================================
module packed_record_fifo #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 16,
    parameter int MERGE  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [TAG_W-1:0]           in_tag,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [TAG_W-1:0]           out_tag,
    output logic [7:0]                 out_len,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH+1);

    // Record layout, MSB first: {hdr.tag, hdr.len, data}
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [7:0]       len;
    } hdr_t;

    typedef struct packed {
        hdr_t              hdr;
        logic [DATA_W-1:0] data;
    } rec_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    rec_t               mem_q [DEPTH];
    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_CNT_W-1:0] count_q,  count_d;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_wr_acc;
    logic               w_pop;
    logic               w_merge;
    logic               w_push;
    logic               w_merge_ok;
    logic [c_PTR_W-1:0] w_tail_ptr;
    rec_t               w_tail;
    rec_t               w_head;

    // Both flags depend on the registered count only, so there is no
    // combinational path from the inputs to either of them.
    assign w_in_ready  = (count_q != c_CNT_W'(DEPTH));
    assign w_out_valid = (count_q != '0);

    assign w_wr_acc    = in_valid  && w_in_ready;
    assign w_pop       = out_ready && w_out_valid;

    // The tail is the most recently written slot, one behind wr_ptr.
    assign w_tail_ptr  = wr_ptr_q - c_PTR_W'(1);
    assign w_tail      = mem_q[w_tail_ptr];
    assign w_head      = mem_q[rd_ptr_q];

    // Coalescing condition without the MERGE gate. A tail that is leaving
    // this cycle (sole entry, being popped) must not absorb the write,
    // otherwise the new data would be lost with the popped record.
    assign w_merge_ok  = w_wr_acc
                      && w_out_valid
                      && (in_tag == w_tail.hdr.tag)
                      && (w_tail.hdr.len != 8'hFF)
                      && !((count_q == c_CNT_W'(1)) && w_pop);

    generate
        if (MERGE != 0) begin : g_merge
            assign w_merge = w_merge_ok;
        end else begin : g_no_merge
            assign w_merge = 1'b0;
        end
    endgenerate

    assign w_push = w_wr_acc && !w_merge;

    // ------------------------------------------------------------------
    // Next-state for pointers and occupancy
    // ------------------------------------------------------------------
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
        end

        // A merge adds no entry, so only push and pop move the count.
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_CNT_W'(1);
            2'b01:   count_d = count_q - c_CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Record storage. Contents are don't-care after reset, so the array
    // has no reset; only the writes are suppressed while rst is high.
    // A merge rewrites only the tail's len and data fields and leaves
    // its tag alone.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_push) begin
                mem_q[wr_ptr_q].hdr.tag <= in_tag;
                mem_q[wr_ptr_q].hdr.len <= 8'd1;
                mem_q[wr_ptr_q].data    <= in_data;
            end else if (w_merge) begin
                mem_q[w_tail_ptr].hdr.len <= w_tail.hdr.len + 8'd1;
                mem_q[w_tail_ptr].data    <= w_tail.data + in_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: the head record fields, forced to zero when empty
    // ------------------------------------------------------------------
    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign count     = count_q;
    assign out_tag   = w_out_valid ? w_head.hdr.tag : '0;
    assign out_len   = w_out_valid ? w_head.hdr.len : '0;
    assign out_data  = w_out_valid ? w_head.data    : '0;

endmodule
`default_nettype wire

// File: tb/tb_packed_record_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_packed_record_fifo
// Purpose  : Directed self-checking bench for packed_record_fifo. One
//            instance runs with coalescing enabled and one with it disabled.
// Revision : 1.0  initial release
// ============================================================================
module tb_packed_record_fifo;

    logic        clk = 1'b0;
    logic        rst;

    // MERGE=1 instance
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  in_tag, out_tag;
    logic [15:0] in_data, out_data;
    logic [7:0]  out_len;
    logic [2:0]  count;

    // MERGE=0 instance
    logic        in_valid0, in_ready0, out_valid0, out_ready0;
    logic [3:0]  in_tag0, out_tag0;
    logic [15:0] in_data0, out_data0;
    logic [7:0]  out_len0;
    logic [2:0]  count0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [28:0] head, head0;
    assign head  = {out_valid,  out_tag,  out_len,  out_data};
    assign head0 = {out_valid0, out_tag0, out_len0, out_data0};

    always #5 clk = ~clk;

    packed_record_fifo #(.DEPTH(4), .TAG_W(4), .DATA_W(16), .MERGE(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
        .out_len(out_len), .out_data(out_data), .count(count)
    );

    packed_record_fifo #(.DEPTH(4), .TAG_W(4), .DATA_W(16), .MERGE(0)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_tag(in_tag0), .in_data(in_data0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_tag(out_tag0),
        .out_len(out_len0), .out_data(out_data0), .count(count0)
    );

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single-cycle write into the MERGE=1 instance.
    task automatic wr(input logic [3:0] t, input logic [15:0] d);
        in_valid = 1'b1; in_tag = t; in_data = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 0; in_tag = 0; in_data = 0; out_ready = 0;
        in_valid0 = 0; in_tag0 = 0; in_data0 = 0; out_ready0 = 0;
        step(); step();
        rst = 1'b0;
        n_checks++;
        if (count !== 3'd0) begin
            $display("FAIL reset_count: got %0d expected 0", count); n_fail++;
        end
        n_checks++;
        if ({in_ready, head} !== {1'b1, 29'd0}) begin
            $display("FAIL reset_outputs: got ready=%b head=%h expected ready=1 head=0", in_ready, head); n_fail++;
        end
    endtask

    task automatic test_push_pop();
        wr(4'd1, 16'h0010);
        wr(4'd2, 16'h0020);
        wr(4'd3, 16'h0030);
        n_checks++;
        if (count !== 3'd3) begin
            $display("FAIL pp_count: got %0d expected 3", count); n_fail++;
        end
        out_ready = 1'b1;
        n_checks++;
        if (head !== {1'b1, 4'd1, 8'd1, 16'h0010}) begin
            $display("FAIL pp_head1: got %h expected %h", head, {1'b1, 4'd1, 8'd1, 16'h0010}); n_fail++;
        end
        step();
        n_checks++;
        if (head !== {1'b1, 4'd2, 8'd1, 16'h0020}) begin
            $display("FAIL pp_head2: got %h expected %h", head, {1'b1, 4'd2, 8'd1, 16'h0020}); n_fail++;
        end
        step();
        n_checks++;
        if (head !== {1'b1, 4'd3, 8'd1, 16'h0030}) begin
            $display("FAIL pp_head3: got %h expected %h", head, {1'b1, 4'd3, 8'd1, 16'h0030}); n_fail++;
        end
        step();
        out_ready = 1'b0;
        n_checks++;
        if ({count, head} !== {3'd0, 29'd0}) begin
            $display("FAIL pp_empty: got count=%0d head=%h expected 0/0", count, head); n_fail++;
        end
    endtask

    task automatic test_merge();
        logic [15:0] vals [3];
        vals[0] = 16'hFFF0; vals[1] = 16'h0020; vals[2] = 16'h0001;
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1; in_tag  = 4'd5; in_data  = vals[i];
            in_valid0 = 1; in_tag0 = 4'd5; in_data0 = vals[i];
            step();
        end
        in_valid = 0; in_valid0 = 0;
        n_checks++;
        if ({count, head} !== {3'd1, 1'b1, 4'd5, 8'd3, 16'h0011}) begin
            $display("FAIL merge_tail: got count=%0d head=%h expected count=1 head=%h",
                     count, head, {1'b1, 4'd5, 8'd3, 16'h0011}); n_fail++;
        end
        n_checks++;
        if (count0 !== 3'd3) begin
            $display("FAIL nomerge_count: got %0d expected 3", count0); n_fail++;
        end
        out_ready0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (head0 !== {1'b1, 4'd5, 8'd1, vals[i]}) begin
                $display("FAIL nomerge_head%0d: got %h expected %h", i, head0, {1'b1, 4'd5, 8'd1, vals[i]}); n_fail++;
            end
            step();
        end
        out_ready0 = 1'b0;
        n_checks++;
        if (count0 !== 3'd0) begin
            $display("FAIL nomerge_drain: got %0d expected 0", count0); n_fail++;
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_race();
        wr(4'd7, 16'h0009);
        in_valid = 1; in_tag = 4'd7; in_data = 16'h0004; out_ready = 1;
        step();
        in_valid = 0; out_ready = 0;
        n_checks++;
        if ({count, head} !== {3'd1, 1'b1, 4'd7, 8'd1, 16'h0004}) begin
            $display("FAIL race: got count=%0d head=%h expected count=1 head=%h",
                     count, head, {1'b1, 4'd7, 8'd1, 16'h0004}); n_fail++;
        end
        out_ready = 1;
        step();
        out_ready = 0;
    endtask

    task automatic test_full();
        for (int i = 1; i <= 4; i++) wr(4'(i), 16'h00A0 + 16'(i));
        n_checks++;
        if ({count, in_ready} !== {3'd4, 1'b0}) begin
            $display("FAIL full_flags: got count=%0d ready=%b expected 4/0", count, in_ready); n_fail++;
        end
        // Matching tail tag while full must be neither merged nor pushed.
        in_valid = 1; in_tag = 4'd4; in_data = 16'h0001;
        step(); step();
        in_valid = 0;
        n_checks++;
        if (count !== 3'd4) begin
            $display("FAIL full_hold: got %0d expected 4", count); n_fail++;
        end
        out_ready = 1; step(); out_ready = 0;
        wr(4'd5, 16'h00A5);
        n_checks++;
        if (count !== 3'd4) begin
            $display("FAIL full_refill: got %0d expected 4", count); n_fail++;
        end
        out_ready = 1;
        for (int i = 2; i <= 5; i++) begin
            n_checks++;
            if (head !== {1'b1, 4'(i), 8'd1, 16'h00A0 + 16'(i)}) begin
                $display("FAIL full_order%0d: got %h expected %h", i, head, {1'b1, 4'(i), 8'd1, 16'h00A0 + 16'(i)}); n_fail++;
            end
            step();
        end
        out_ready = 0;
    endtask

    task automatic test_saturation();
        do_reset();
        in_valid = 1; in_tag = 4'd2; in_data = 16'h0001;
        repeat (255) step();
        in_valid = 0;
        n_checks++;
        if ({count, head} !== {3'd1, 1'b1, 4'd2, 8'd255, 16'h00FF}) begin
            $display("FAIL sat_tail: got count=%0d head=%h expected count=1 head=%h",
                     count, head, {1'b1, 4'd2, 8'd255, 16'h00FF}); n_fail++;
        end
        wr(4'd2, 16'h0001);
        n_checks++;
        if (count !== 3'd2) begin
            $display("FAIL sat_push: got count=%0d expected 2", count); n_fail++;
        end
        out_ready = 1; step(); out_ready = 0;
        n_checks++;
        if (head !== {1'b1, 4'd2, 8'd1, 16'h0001}) begin
            $display("FAIL sat_new: got %h expected %h", head, {1'b1, 4'd2, 8'd1, 16'h0001}); n_fail++;
        end
        out_ready = 1; step(); out_ready = 0;
    endtask

    task automatic test_mid_reset();
        wr(4'd1, 16'h0111);
        wr(4'd2, 16'h0222);
        wr(4'd3, 16'h0333);
        n_checks++;
        if (count !== 3'd3) begin
            $display("FAIL mr_pre: got %0d expected 3", count); n_fail++;
        end
        rst = 1; in_valid = 1; in_tag = 4'd3; in_data = 16'h0005; out_ready = 1;
        step();
        rst = 0; in_valid = 0; out_ready = 0;
        n_checks++;
        if ({count, in_ready, head} !== {3'd0, 1'b1, 29'd0}) begin
            $display("FAIL mid_reset: got count=%0d ready=%b head=%h expected 0/1/0", count, in_ready, head); n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_merge();
        test_race();
        test_full();
        test_saturation();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
